clock_lock_supervisor: RTL and testbench

- Supervises the clock-generation unit from the free-running board clock (125 MHz).
- Drives the clock unit's active-high PLL reset and consumes its lock output.
- Qualifies lock with a stability window, then asserts a clean o_valid for downstream reset release.
- On loss of lock or lock timeout, re-resets the PLL automatically and counts the events for status readout.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/clock_lock_supervisor.sv | 147 ++++++++++++++
 tb/tb_clock_lock_supervisor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock lock supervisor: FSM state encoding,
// default cycle constants and the shared down-counter width helper.
`timescale 1ns / 1ps

package clock_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } lock_state_e;

  // Defaults sized for a 125 MHz board clock.
  localparam int unsigned DefStableCycles      = 1024;
  localparam int unsigned DefPllResetCycles    = 16;
  localparam int unsigned DefLockTimeoutCycles = 125000;
  localparam int unsigned DefCountWidth        = 8;

  // Width of a down-counter that must hold (largest cycle count - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow-changing asynchronous inputs.
// Parameterizable width; each bit is synchronized independently.
`timescale 1ns / 1ps

module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops; first stage may go metastable, second resolves it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_lock_supervisor.sv
// Clock lock supervisor: pulses the PLL reset, waits for lock, qualifies it
// over a stability window and then raises o_valid. Loss of lock or a lock
// timeout re-resets the PLL automatically.
// Optional: define CLOCK_LOCK_SUPERVISOR_COUNTERS_EN to implement the
// saturating lock-loss / timeout event counters; otherwise they read 0.
`timescale 1ns / 1ps

module clock_lock_supervisor
  import clock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES       = DefStableCycles,
  parameter int unsigned PLL_RESET_CYCLES    = DefPllResetCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned COUNT_WIDTH         = DefCountWidth
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_locked,
  output logic                   o_pll_reset,
  output logic                   o_valid,
  output logic [COUNT_WIDTH-1:0] o_lock_loss_count,
  output logic [COUNT_WIDTH-1:0] o_timeout_count
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, PLL_RESET_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);

  // Reload values for each state entry.
  localparam logic [CntW-1:0] PllRstLoad  = CntW'(PLL_RESET_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLoad  = CntW'(STABLE_CYCLES - 1);

  lock_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            pll_reset_q;
  logic            valid_q;
  logic            locked_s;
  logic            cnt_zero;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .d_i    (i_locked),
    .q_o    (locked_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // Supervisor FSM with shared down-counter and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= PllRstLoad;
      pll_reset_q <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          // Lock is meaningless while the PLL is held in reset.
          if (cnt_zero) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= TimeoutLoad;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over an expiring timeout.
          if (locked_s) begin
            state_q <= STABLE;
            cnt_q   <= StableLoad;
          end else if (cnt_zero) begin
            state_q     <= PLL_RST;
            cnt_q       <= PllRstLoad;
            pll_reset_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= TimeoutLoad;
          end else if (cnt_zero) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q     <= PLL_RST;
            cnt_q       <= PllRstLoad;
            pll_reset_q <= 1'b1;
            valid_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= PLL_RST;
          cnt_q       <= PllRstLoad;
          pll_reset_q <= 1'b1;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_reset = pll_reset_q;
  assign o_valid     = valid_q;

`ifdef CLOCK_LOCK_SUPERVISOR_COUNTERS_EN
  logic                   lock_loss_evt;
  logic                   timeout_evt;
  logic [COUNT_WIDTH-1:0] lock_loss_cnt_q;
  logic [COUNT_WIDTH-1:0] timeout_cnt_q;

  // Events mirror the RUN->PLL_RST and WAIT_LOCK timeout transitions above.
  assign lock_loss_evt = (state_q == RUN) && !locked_s;
  assign timeout_evt   = (state_q == WAIT_LOCK) && !locked_s && cnt_zero;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      lock_loss_cnt_q <= '0;
      timeout_cnt_q   <= '0;
    end else begin
      if (lock_loss_evt && (lock_loss_cnt_q != '1)) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + COUNT_WIDTH'(1);
      end
      if (timeout_evt && (timeout_cnt_q != '1)) begin
        timeout_cnt_q <= timeout_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign o_lock_loss_count = lock_loss_cnt_q;
  assign o_timeout_count   = timeout_cnt_q;
`else
  assign o_lock_loss_count = '0;
  assign o_timeout_count   = '0;
`endif

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Directed bench for clock_lock_supervisor (small parameters).
// Cycle k is the falling edge just before rising edge k: inputs set there are
// sampled at edge k, and outputs read there are the values "at edge k".
`timescale 1ns / 1ps

module tb_clock_lock_supervisor;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          locked;
  logic          pll_reset;
  logic          valid;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] to_cnt;

  int n_tests;
  int n_fail;
  int cyc;

  clock_lock_supervisor #(
    .STABLE_CYCLES       (8),
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .COUNT_WIDTH         (CW)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_locked          (locked),
    .o_pll_reset       (pll_reset),
    .o_valid           (valid),
    .o_lock_loss_count (loss_cnt),
    .o_timeout_count   (to_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected counter value; counters read 0 when they are compiled out.
  function automatic int unsigned ecnt(input int unsigned v);
`ifdef CLOCK_LOCK_SUPERVISOR_COUNTERS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Advance to cycle k, checking output exclusivity at every step.
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
      check("excl", {31'd0, pll_reset & valid}, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pll", pll_reset, 1);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    locked  = 1'b0;

    // 1: reset pulse, then repeated lock timeouts with saturation.
    do_reset();
    check("rst_loss", loss_cnt, 0);
    check("rst_to", to_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      go_to(k);
      check("pulse0_hi", pll_reset, 1);
    end
    go_to(4);  check("pulse0_lo", pll_reset, 0);
    go_to(23); check("to1_before", pll_reset, 0);
    check("to1_cnt_before", to_cnt, ecnt(0));
    go_to(24); check("to1_pll", pll_reset, 1);
    check("to1_cnt", to_cnt, ecnt(1));
    go_to(27); check("to1_pulse_end", pll_reset, 1);
    go_to(28); check("to1_pulse_lo", pll_reset, 0);
    go_to(48); check("to2_cnt", to_cnt, ecnt(2));
    go_to(72); check("to3_cnt", to_cnt, ecnt(3));
    go_to(121); check("to5_sat", to_cnt, ecnt(3));
    check("to_no_loss", loss_cnt, 0);

    // 2: lock at edge 10 -> valid at edge 21.
    do_reset();
    go_to(10); locked = 1'b1;
    go_to(20); check("lat_valid_early", valid, 0);
    go_to(21); check("lat_valid", valid, 1);
    check("lat_pll", pll_reset, 0);
    check("lat_loss", loss_cnt, 0);
    check("lat_to", to_cnt, 0);

    // 2b: lock arrives on the timeout cycle -> lock wins.
    do_reset();
    go_to(21); locked = 1'b1;
    go_to(24); check("win_pll", pll_reset, 0);
    check("win_to", to_cnt, 0);
    go_to(31); check("win_valid_early", valid, 0);
    go_to(32); check("win_valid", valid, 1);

    // 2c: lock one cycle too late -> timeout, lock ignored during PLL reset.
    do_reset();
    go_to(22); locked = 1'b1;
    go_to(24); check("late_pll", pll_reset, 1);
    check("late_to", to_cnt, ecnt(1));
    go_to(36); check("late_valid_early", valid, 0);
    go_to(37); check("late_valid", valid, 1);

    // 3: glitch low during STABLE restarts qualification.
    do_reset();
    go_to(10); locked = 1'b1;
    go_to(14); locked = 1'b0;
    go_to(17); locked = 1'b1;
    go_to(20); check("glitch_pll", pll_reset, 0);
    go_to(27); check("glitch_valid_early", valid, 0);
    go_to(28); check("glitch_valid", valid, 1);
    check("glitch_loss", loss_cnt, 0);
    check("glitch_to", to_cnt, 0);

    // 4/5: four lock losses from RUN, loss count saturates at 3.
    for (int i = 0; i < 4; i++) begin
      int d;
      d = 40 + 30 * i;
      go_to(d);      locked = 1'b0;
      go_to(d + 2);  check("loss_valid_hold", valid, 1);
      check("loss_pll_hold", pll_reset, 0);
      go_to(d + 3);  check("loss_valid", valid, 0);
      check("loss_pll", pll_reset, 1);
      check("loss_cnt", loss_cnt, ecnt((i < 3) ? i + 1 : 3));
      go_to(d + 6);  check("loss_pulse_end", pll_reset, 1);
      go_to(d + 7);  check("loss_pulse_lo", pll_reset, 0);
      go_to(d + 10); locked = 1'b1;
      go_to(d + 21); check("relock_valid", valid, 1);
    end
    check("loss_to", to_cnt, 0);

    // 6: asynchronous reset mid-RUN, between clock edges.
    go_to(155);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", valid, 0);
    check("async_pll", pll_reset, 1);
    check("async_loss", loss_cnt, 0);
    check("async_to", to_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
